// File: rtl/aes_chain_decrypt.sv
// Streaming AES-128 block decryptor with ECB / CBC / PCBC chaining.
// Holds a session state machine, a chaining register, a block counter and
// valid/ready handshakes around a purely combinational AES-128 inverse cipher.

// Combinational AES-128 inverse cipher, including key expansion.
module aesdecrypt (
    input  logic [127:0] i_ct,
    input  logic [127:0] i_key,
    output logic [127:0] o_pt
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        logic [7:0] p = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = xtime(p);
        end
        return r;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        logic [7:0] p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v = gf_inv(a);
        return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

    // State byte k (column-major, k = 4*col + row) lives at bits [127-8k -: 8].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o = '0;
        for (int k = 0; k < 16; k++)
            o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o = '0;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    function automatic logic [127:0] aes_decrypt_block(input logic [127:0] ct, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rcon = 8'h01;
        logic [127:0] s;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        s = ct ^ {w[40], w[41], w[42], w[43]};
        for (int r = 9; r >= 1; r--)
            s = inv_mix_columns(inv_sub_bytes(inv_shift_rows(s)) ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
        return inv_sub_bytes(inv_shift_rows(s)) ^ {w[0], w[1], w[2], w[3]};
    endfunction

    assign o_pt = aes_decrypt_block(i_ct, i_key);
endmodule

module aes_chain_decrypt #(
    parameter int CNT_W      = 32,
    parameter int MAX_BLOCKS = 65536
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode_in,
    input  logic [127:0]     key_in,
    input  logic [127:0]     iv_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic [CNT_W-1:0] blk_cnt,
    output logic             busy,
    output logic             done,
    output logic             err
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    localparam logic [1:0]       MODE_ECB  = 2'b00;
    localparam logic [1:0]       MODE_PCBC = 2'b10;
    localparam logic [1:0]       MODE_ILL  = 2'b11;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(MAX_BLOCKS - 1);

    state_t             r_state, w_next_state;
    logic [1:0]         r_mode;
    logic [127:0]       r_key, r_chain, r_out_data;
    logic               r_out_valid, r_err, r_done;
    logic [CNT_W-1:0]   r_blk_cnt;
    logic               w_in_ready, w_accept, w_take, w_done_next;
    logic [127:0]       w_dec, w_plain, w_chain_next;

    aesdecrypt u_core (.i_ct(in_data), .i_key(r_key), .o_pt(w_dec));

    // Single output stage: a new block may enter whenever the stage is empty or being emptied.
    assign w_in_ready   = (r_state == ST_RUN) && (!r_out_valid || out_ready);
    assign w_accept     = in_valid && w_in_ready;
    assign w_take       = r_out_valid && out_ready;
    assign w_plain      = (r_mode == MODE_ECB) ? w_dec : (w_dec ^ r_chain);
    // PCBC chains C_i ^ P_i; CBC chains C_i.
    assign w_chain_next = (r_mode == MODE_PCBC) ? (in_data ^ w_plain) : in_data;

    // Next-state logic and the session-end pulse.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        w_next_state = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE:  if (start && mode_in != MODE_ILL) w_next_state = ST_RUN;
            ST_RUN:   if (w_accept && r_blk_cnt == LAST_CNT) w_next_state = ST_DRAIN;
            ST_DRAIN: if (!r_out_valid || out_ready) begin
                          w_next_state = ST_IDLE;
                          w_done_next  = 1'b1;
                      end
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // State register and done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_done_next;
        end
    end

    // Session context: key, mode, chaining value, block count and the sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_key     <= '0;
            r_mode    <= MODE_ECB;
            r_chain   <= '0;
            r_blk_cnt <= '0;
            r_err     <= 1'b0;
        end else if (r_state == ST_IDLE && start) begin
            if (mode_in == MODE_ILL) begin
                r_err <= 1'b1;
            end else begin
                r_key     <= key_in;
                r_mode    <= mode_in;
                r_chain   <= iv_in;
                r_blk_cnt <= '0;
                r_err     <= 1'b0;
            end
        end else if (w_accept) begin
            r_blk_cnt <= r_blk_cnt + CNT_W'(1);
            if (r_mode != MODE_ECB) r_chain <= w_chain_next;
        end
    end

    // Output register: loads on accept, empties on take, holds under back-pressure.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_plain;
        end else if (w_take) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign blk_cnt   = r_blk_cnt;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign err       = r_err;
endmodule

// File: tb/tb_aes_chain_decrypt.sv
// Directed scoreboard bench for aes_chain_decrypt (session length 4 blocks).
module tb_aes_chain_decrypt;
    localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CF   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PF   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] IVF  = 128'h0f1571c947d9e8590cb7add6af7f6798;
    localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV2  = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk, reset, start, in_valid, in_ready, out_valid, out_ready, busy, done, err;
    logic [1:0]   mode_in;
    logic [127:0] key_in, iv_in, in_data, out_data;
    logic [31:0]  blk_cnt;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           done_cnt = 0;
    logic [127:0] exp_q [$];
    logic [127:0] tx_c [8];
    logic [127:0] tx_p [8];

    aes_chain_decrypt #(.CNT_W(32), .MAX_BLOCKS(4)) dut (
        .clk(clk), .reset(reset), .start(start), .mode_in(mode_in), .key_in(key_in),
        .iv_in(iv_in), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .blk_cnt(blk_cnt), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake and counts done pulses.
    always @(negedge clk) begin
        logic [127:0] e;
        #3;
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got %h expected no output", out_data);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", out_data, e);
            end
        end
        if (done) done_cnt++;
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},  in_ready,  0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"},  out_data,  0);
        check({tag, "_blk_cnt"},   blk_cnt,   0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
        check({tag, "_err"},       err,       0);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        #1 check_reset_vals({tag, "_rst"});
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1 check_reset_vals({tag, "_post"});
        done_cnt = 0;
    endtask

    // Opens a session, then scrambles key/iv inputs to show they were latched.
    task automatic open_session(input logic [1:0] m, input logic [127:0] k, input logic [127:0] iv);
        @(negedge clk);
        start = 1'b1; mode_in = m; key_in = k; iv_in = iv;
        @(negedge clk);
        start = 1'b0; key_in = ~k; iv_in = ~iv; mode_in = 2'b11;
    endtask

    // Offers tx_c[0..n-1]; out_ready is low for stall_len cycles from stall_start.
    task automatic run_stream(input int n, input int stall_start, input int stall_len, input logic final_ready);
        int idx = 0;
        int cyc = 0;
        while (idx < n && cyc < 200) begin
            @(negedge clk);
            out_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
            in_valid  = 1'b1;
            in_data   = tx_c[idx];
            #1;
            if (!out_ready && out_valid && idx > 0) begin
                check("stall_in_ready", in_ready, 0);
                check("stall_data", out_data, tx_p[idx-1]);
            end
            if (in_ready) begin
                exp_q.push_back(tx_p[idx]);
                idx++;
            end
            cyc++;
        end
        if (idx < n) check("stream_timeout", idx, n);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = final_ready;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (!busy) break;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; mode_in = 2'b00; key_in = '0; iv_in = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1 check_reset_vals("init");
        reset = 1'b1;
        @(negedge clk);
        #1 check_reset_vals("init_rel");

        // ECB, FIPS-197 vector, one-cycle latency.
        open_session(2'b00, K1, '0);
        tx_c[0] = CF; tx_p[0] = PF;
        run_stream(1, -1, 0, 1'b1);
        #1;
        check("ecb_valid", out_valid, 1);
        check("ecb_data", out_data, PF);
        check("ecb_cnt", blk_cnt, 1);
        wait_drain("ecb");
        pulse_reset("ecb");

        // CBC with the same ciphertext twice.
        open_session(2'b01, K1, IVF);
        tx_c[0] = CF; tx_p[0] = PF ^ IVF;
        tx_c[1] = CF; tx_p[1] = PF ^ CF;
        run_stream(2, -1, 0, 1'b1);
        wait_drain("cbc");
        check("cbc_cnt", blk_cnt, 2);
        pulse_reset("cbc");

        // PCBC, zero IV: P, then C ^ P ^ P = C.
        open_session(2'b10, K1, '0);
        tx_c[0] = CF; tx_p[0] = PF;
        tx_c[1] = CF; tx_p[1] = CF;
        run_stream(2, -1, 0, 1'b1);
        wait_drain("pcbc");
        check("pcbc_cnt", blk_cnt, 2);
        pulse_reset("pcbc");

        // Back-pressure: SP 800-38A CBC stream, 3-cycle stall mid-stream, full session.
        open_session(2'b01, K2, IV2);
        tx_c[0] = 128'h7649abac8119b246cee98e9b12e9197d; tx_p[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
        tx_c[1] = 128'h5086cb9b507219ee95db113a917678b2; tx_p[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        tx_c[2] = 128'h73bed6b8e3c1743b7116e69e22229516; tx_p[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
        tx_c[3] = 128'h3ff1caa1681fac09120eca307586e1a7; tx_p[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
        run_stream(4, 2, 3, 1'b1);
        wait_drain("bp");
        wait_idle("bp");
        check("bp_cnt", blk_cnt, 4);
        check("bp_done_cnt", done_cnt, 1);

        // Session end: SP 800-38A ECB stream, six blocks offered, four accepted.
        done_cnt = 0;
        open_session(2'b00, K2, '0);
        tx_c[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        tx_c[1] = 128'hf5d3d58503b9699de785895a96fdbaaf;
        tx_c[2] = 128'h43b1cd7f598ece23881b00e3ed030688;
        tx_c[3] = 128'h7b0c785e27e8ad3f8223207104725dd4;
        run_stream(4, -1, 0, 1'b0);
        in_valid = 1'b1;
        in_data  = tx_c[0];
        for (int i = 0; i < 2; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check("drain_in_ready", in_ready, 0);
            check("drain_busy", busy, 1);
            check("drain_data", out_data, tx_p[3]);
            check("drain_done", done, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_data   = tx_c[1];
        #1 check("drain_take_in_ready", in_ready, 0);
        @(negedge clk);
        #1;
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_in_ready", in_ready, 0);
        check("end_out_valid", out_valid, 0);
        check("end_cnt", blk_cnt, 4);
        @(negedge clk);
        #1;
        check("end_done_low", done, 0);
        check("end_idle_in_ready", in_ready, 0);
        check("end_cnt_hold", blk_cnt, 4);
        in_valid = 1'b0;
        check("end_done_cnt", done_cnt, 1);
        check("end_q_empty", exp_q.size(), 0);

        // Illegal mode sets a sticky err; a legal start clears it.
        @(negedge clk);
        start = 1'b1; mode_in = 2'b11; key_in = K1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("ill_err", err, 1);
        check("ill_busy", busy, 0);
        check("ill_in_ready", in_ready, 0);
        @(negedge clk);
        #1 check("ill_err_sticky", err, 1);
        open_session(2'b00, K1, '0);
        #1;
        check("legal_err_clr", err, 0);
        check("legal_busy", busy, 1);
        check("legal_cnt_clr", blk_cnt, 0);

        // Reset mid-session with an output still pending.
        tx_c[0] = CF; tx_p[0] = PF;
        tx_c[1] = CF; tx_p[1] = PF;
        run_stream(2, -1, 0, 1'b0);
        #1;
        check("mid_cnt", blk_cnt, 2);
        check("mid_valid", out_valid, 1);
        reset = 1'b0;
        #1 check_reset_vals("mid_rst");
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1 check_reset_vals("mid_post");
        out_ready = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
